fixed_point_divider: RTL and testbench
======================================

Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider for the Q(WIDTH-FBITS).FBITS format the Fixed_Point_Unit uses (Q22.10 at defaults).
- Inverse companion to the FPU multiplier: quotient = (dividend << FBITS) / divisor, one quotient bit per clock, restoring algorithm.
- Sits beside the FPU datapath. Driven through a start/ready handshake by the execute stage, for FPU_DIV.

Parameters:
- WIDTH, 32, operand and result width in bits.
- FBITS, 10, number of fractional bits.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse/level; sampled only in IDLE or DONE.
- dividend  input  WIDTH  signed fixed-point numerator.
- divisor  input  WIDTH  signed fixed-point denominator.
- quotient  output  WIDTH  signed fixed-point result, registered.
- ready  output  1  result valid; level, held until the next accepted start.
- busy  output  1  high while in DIVIDE or FIXUP.
- div_by_zero  output  1  divisor was zero; valid with ready.
- overflow  output  1  result saturated; valid with ready.

Behaviour:
- Reset (async, immediate): state=IDLE; quotient=0; ready=0; busy=0; div_by_zero=0; overflow=0.
- Reset mid-operation aborts with no partial result. start is ignored while reset is high.
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE, or DONE, with start=1 at edge E0:
  - latch sign_q = dividend[MSB] ^ divisor[MSB];
  - latch |dividend| and |divisor| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1), which is representable);
  - numerator register = |dividend| << FBITS, WIDTH+FBITS bits;
  - remainder = 0; iteration counter = WIDTH+FBITS; ready cleared; busy set.
  - If divisor==0: set div_by_zero and go straight to FIXUP; otherwise go to DIVIDE.
- DIVIDE, once per cycle:
  - trial = {remainder, numerator MSB} − |divisor|, with remainder WIDTH+1 bits;
  - if trial ≥ 0: remainder = trial and shift in quotient bit 1; else keep the shifted remainder and shift in 0;
  - decrement the counter; go to FIXUP after WIDTH+FBITS iterations.
- FIXUP, one cycle:
  - if magnitude > 2^(WIDTH-1)−1 for positive results, or > 2^(WIDTH-1) for negative results: quotient saturates to 0x7FFF_FFFF or 0x8000_0000 and overflow=1;
  - if div_by_zero: quotient = 0x7FFF_FFFF when dividend ≥ 0, 0x8000_0000 when dividend < 0; overflow stays 0;
  - else quotient = sign_q ? −magnitude : magnitude;
  - rounding: truncation toward zero;
  - go to DONE; busy drops.
- DONE: ready=1; quotient and flags hold until the next accepted start.
- Latency: ready high after edge E0+WIDTH+FBITS+2 (E0+44 at defaults); after E0+2 for divide-by-zero.
- Handshake:
  - start during DIVIDE or FIXUP is ignored; no queueing.
  - start held high in DONE restarts the divider, so ready is a 1-cycle level in that case.
  - A zero dividend still takes full latency; no early exit, so latency is deterministic.
- Result bit 0 equals numerator/divisor truncated. Remainder is internal only, not output.

Optional Feature:
- Macro: FPU_DIV_ROUND_EN.
- Defined:
  - one extra iteration (WIDTH+FBITS+1) produces a guard bit;
  - the magnitude is rounded half away from zero before sign application and saturation check;
  - latency becomes WIDTH+FBITS+3;
  - a round-up that exceeds range saturates and sets overflow.
- Undefined: truncation and latency as above.

Decomposition:
- Defines.vh gains:
  - FPU_DIV opcode constant;
  - divider state encodings DIV_IDLE, DIV_DIVIDE, DIV_FIXUP, DIV_DONE (2 bits);
  - Q-format max/min constants FX_MAX and FX_MIN.
- One natural sub-module, fixed_point_div_step:
  - combinational restoring step (remainder_in, numerator_bit, divisor_abs → remainder_out, q_bit);
  - keeps the FSM file focused on control.

Test Plan:
- 3.0/2.0: dividend=3072, divisor=2048, start 1 cycle → ready at E0+44; quotient=1536; flags 0.
- −7.5/2.5: −7680 / 2560 → quotient=−3072 (0xFFFF_F400); flags 0.
- 2/3 rounding: 2048 / 3072 → quotient=682 without FPU_DIV_ROUND_EN; quotient=683 with it (latency 45).
- Divide by zero:
  - 5120 / 0 → ready at E0+2; quotient=0x7FFF_FFFF; div_by_zero=1;
  - −5120 / 0 → quotient=0x8000_0000.
- Overflow: 0x7FFF_FFFF / 1 → quotient=0x7FFF_FFFF, overflow=1; also 0x8000_0000 / −1024 → 0x7FFF_FFFF, overflow=1.
- Control:
  - start re-pulsed at E0+10 with new operands is ignored; the result matches the first operands;
  - reset asserted at E0+20 → all outputs 0 immediately;
  - the next start then completes normally at full latency.

Source files
------------

// File: rtl/fixed_point_divider_pkg.sv
// Shared constants for the fixed-point divider: opcode, FSM encodings and Q-format limits.
package fixed_point_divider_pkg;

  localparam logic [4:0] FPU_DIV = 5'd19;

  localparam logic [1:0] DIV_IDLE   = 2'd0;
  localparam logic [1:0] DIV_DIVIDE = 2'd1;
  localparam logic [1:0] DIV_FIXUP  = 2'd2;
  localparam logic [1:0] DIV_DONE   = 2'd3;

  localparam int FX_WIDTH = 32;
  localparam int FX_FBITS = 10;

  localparam logic [FX_WIDTH-1:0] FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
  localparam logic [FX_WIDTH-1:0] FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift in a numerator bit, subtract the divisor if it fits.
module fixed_point_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   remainder_in,
  input  logic             numerator_bit,
  input  logic [WIDTH-1:0] divisor_abs,
  output logic [WIDTH:0]   remainder_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Remainder stays below the divisor, so the extra top bit acts purely as the trial sign.
  assign shifted       = {remainder_in, numerator_bit};
  assign trial         = shifted - {2'b00, divisor_abs};
  assign q_bit         = ~trial[WIDTH+1];
  assign remainder_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed Q-format divider, one quotient bit per clock (restoring).
// Define FPU_DIV_ROUND_EN to round half away from zero using one extra guard iteration.
module fixed_point_divider
  import fixed_point_divider_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int FBITS = FX_FBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

`ifdef FPU_DIV_ROUND_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif
  localparam int NITER = WIDTH + FBITS + GUARD;
  localparam int CW    = $clog2(NITER + 1);
  localparam int MAGW  = NITER + 1;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MAGW-1:0]  LIM_POS = MAGW'(SAT_POS);
  localparam logic [MAGW-1:0]  LIM_NEG = MAGW'(SAT_NEG);

  logic [1:0]       state;
  logic             sign_q;
  logic             dividend_neg;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH-1:0] dividend_abs;
  logic [NITER-1:0] numer;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [CW-1:0]    count;
  logic             accept;
  logic [MAGW-1:0]  mag;
  logic [MAGW-1:0]  limit;
  logic [WIDTH-1:0] fix_quotient;
  logic             fix_overflow;

  // A DONE restart is only taken once ready has been visible for a cycle.
  assign accept       = start && (state == DIV_IDLE || (state == DIV_DONE && ready));
  assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;

  fixed_point_div_step #(.WIDTH(WIDTH)) u_step (
    .remainder_in  (rem),
    .numerator_bit (numer[NITER-1]),
    .divisor_abs   (divisor_abs),
    .remainder_out (rem_next),
    .q_bit         (q_bit)
  );

  // numer doubles as the quotient shift register once its bits have been consumed.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
`ifdef FPU_DIV_ROUND_EN
    mag = MAGW'(numer >> 1) + MAGW'(numer[0]);
`else
    mag = MAGW'(numer);
`endif
    limit        = sign_q ? LIM_NEG : LIM_POS;
    fix_overflow = 1'b0;
    fix_quotient = sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
    if (div_by_zero) begin
      fix_quotient = dividend_neg ? SAT_NEG : SAT_POS;
    end else if (mag > limit) begin
      fix_overflow = 1'b1;
      fix_quotient = sign_q ? SAT_NEG : SAT_POS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: datapath registers are cleared too, so an aborted divide leaves no stale partial state.
    if (reset) begin
      state        <= DIV_IDLE;
      quotient     <= '0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      div_by_zero  <= 1'b0;
      overflow     <= 1'b0;
      sign_q       <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_abs  <= '0;
      numer        <= '0;
      rem          <= '0;
      count        <= '0;
    end else if (accept) begin
      sign_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      dividend_neg <= dividend[WIDTH-1];
      divisor_abs  <= divisor[WIDTH-1] ? -divisor : divisor;
      numer        <= {dividend_abs, {(NITER-WIDTH){1'b0}}};
      rem          <= '0;
      count        <= CW'(NITER);
      ready        <= 1'b0;
      busy         <= 1'b1;
      overflow     <= 1'b0;
      div_by_zero  <= (divisor == '0);
      state        <= (divisor == '0) ? DIV_FIXUP : DIV_DIVIDE;
    end else begin
      case (state)
        DIV_DIVIDE: begin
          numer <= {numer[NITER-2:0], q_bit};
          rem   <= rem_next;
          count <= count - 1'b1;
          if (count == CW'(1)) state <= DIV_FIXUP;
        end
        DIV_FIXUP: begin
          quotient <= fix_quotient;
          overflow <= fix_overflow;
          busy     <= 1'b0;
          state    <= DIV_DONE;
        end
        DIV_DONE: ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench: directed vectors with literal expectations plus an arithmetic reference model.
module tb_fixed_point_divider;
  import fixed_point_divider_pkg::*;

  localparam int FB = 10;
`ifdef FPU_DIV_ROUND_EN
  localparam int LAT = 45;
  localparam logic [31:0] Q_TWO_THIRDS = 32'd683;
`else
  localparam int LAT = 44;
  localparam logic [31:0] Q_TWO_THIRDS = 32'd682;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic        ready;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0     = 0;

  logic [31:0] exp_q;
  logic        exp_dz;
  logic        exp_ov;
  bit          exp_valid = 1'b0;

  fixed_point_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .ready       (ready),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic on the real-valued operands.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic dz, output logic ov);
    longint sa, sb, n, d, m, lim;
    bit neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = (b == 32'd0);
    ov = 1'b0;
    q  = '0;
    if (dz) begin
      q = (sa < 0) ? FX_MIN : FX_MAX;
      return;
    end
    n = ((sa < 0) ? -sa : sa) * (longint'(1) << FB);
    d = (sb < 0) ? -sb : sb;
`ifdef FPU_DIV_ROUND_EN
    m = (2 * n + d) / (2 * d);
`else
    m = n / d;
`endif
    neg = (sa < 0) != (sb < 0);
    lim = neg ? (longint'(1) << 31) : (longint'(1) << 31) - 1;
    if (m > lim) begin
      ov = 1'b1;
      q  = neg ? FX_MIN : FX_MAX;
    end else begin
      q = neg ? 32'(-m) : 32'(m);
    end
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (!reset && exp_valid && ready) begin
      check("cmp quotient", 64'(quotient), 64'(exp_q));
      check("cmp div_by_zero", 64'(div_by_zero), 64'(exp_dz));
      check("cmp overflow", 64'(overflow), 64'(exp_ov));
      check("cmp busy", 64'(busy), 64'd0);
    end
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit hold);
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    e0 = cyc;
    model(a, b, exp_q, exp_dz, exp_ov);
    exp_valid = 1'b1;
  endtask

  task automatic wait_ready(input int lat, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      seen = ready;
    end
    check({name, " latency"}, seen ? 64'(cyc - e0) : 64'hDEAD, 64'(lat));
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lq,
                         input logic ldz, input logic lov, input int lat, input string name);
    do_start(a, b, 1'b0);
    wait_ready(lat, name);
    check({name, " quotient"}, 64'(quotient), 64'(lq));
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(ldz));
    check({name, " overflow"}, 64'(overflow), 64'(lov));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);

    run_div(32'd3072,      32'd2048,      32'd1536,      1'b0, 1'b0, LAT, "3.0/2.0");
    run_div(32'hFFFF_E200, 32'd2560,      32'hFFFF_F400, 1'b0, 1'b0, LAT, "-7.5/2.5");
    run_div(32'd2048,      32'd3072,      Q_TWO_THIRDS,  1'b0, 1'b0, LAT, "2/3");
    run_div(32'hFFFF_FC00, 32'd3072,      32'hFFFF_FEAB, 1'b0, 1'b0, LAT, "-1/3");
    run_div(32'd5120,      32'd0,         FX_MAX,        1'b1, 1'b0, 2,   "5/0");
    run_div(32'hFFFF_EC00, 32'd0,         FX_MIN,        1'b1, 1'b0, 2,   "-5/0");
    run_div(FX_MAX,        32'd1,         FX_MAX,        1'b0, 1'b1, LAT, "max/tiny");
    run_div(FX_MIN,        32'hFFFF_FC00, FX_MAX,        1'b0, 1'b1, LAT, "min/-1.0");
    run_div(FX_MIN,        32'd1024,      FX_MIN,        1'b0, 1'b0, LAT, "min/1.0");
    run_div(32'd0,         32'd3072,      32'd0,         1'b0, 1'b0, LAT, "0/3");

    // start during DIVIDE must be ignored
    do_start(32'd3072, 32'd2048, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd1000;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(LAT, "ignored restart");
    check("ignored restart quotient", 64'(quotient), 64'd1536);
    repeat (2) @(posedge clk);

    // asynchronous abort mid-divide
    do_start(32'd2048, 32'd3072, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("pre-abort busy", 64'(busy), 64'd1);
    exp_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort quotient", 64'(quotient), 64'd0);
    check("abort ready", 64'(ready), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort flags", 64'({div_by_zero, overflow}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_div(32'd3072, 32'd2048, 32'd1536, 1'b0, 1'b0, LAT, "post-abort");

    // start held high through DONE: ready lasts one cycle, then a new divide begins
    do_start(32'hFFFF_E200, 32'd2560, 1'b1);
    wait_ready(LAT, "held start");
    @(posedge clk); #1;
    check("held start ready pulse", 64'(ready), 64'd0);
    check("held start busy", 64'(busy), 64'd1);
    start = 1'b0;
    e0 = cyc;
    wait_ready(LAT, "held restart");
    check("held restart quotient", 64'(quotient), 64'hFFFF_F400);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
